// File: rtl/crc_frame_pkg.sv
// Shared types and helpers for the CRC frame appender: FSM state encoding and trailer word count.
// No logic of its own; imported by crc_frame_appender.
package crc_frame_pkg;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_CRC  = 2'd1,
    S_CLR  = 2'd2
  } state_e;

  function automatic int crc_words(input int crc_size, input int dw);
    return crc_size / dw;
  endfunction

endpackage

// File: rtl/crc_calc.sv
// Parameterised CRC engine, one DATA_WIDTH word per cycle; crc_o reflects words accepted up to the last edge.
// Latency: 1 cycle (registered state, combinational output); no backpressure, valid_i is consumed every cycle.
module crc_calc #(
  parameter logic [63:0] POLY       = 64'h1021,
  parameter int          CRC_SIZE   = 16,
  parameter int          DATA_WIDTH = 8,
  parameter logic [63:0] INIT       = 64'hffff,
  parameter bit          REF_IN     = 1'b1,
  parameter bit          REF_OUT    = 1'b1,
  parameter logic [63:0] XOR_OUT    = 64'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  localparam logic [CRC_SIZE-1:0] P = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] I = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] X = XOR_OUT[CRC_SIZE-1:0];

  logic [CRC_SIZE-1:0]   crc_q, crc_d, crc_raw;
  logic [DATA_WIDTH-1:0] din;
  logic                  fb;

  // The register always holds the unreflected (MSB-first) remainder; reflection is applied at the edges.
  always_comb begin
    din = data_i;
    if (REF_IN) begin
      for (int i = 0; i < DATA_WIDTH; i++) din[i] = data_i[DATA_WIDTH-1-i];
    end
    fb    = 1'b0;
    crc_d = crc_q;
    if (soft_reset_i) begin
      crc_d = I;
    end else if (valid_i) begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        fb    = crc_d[CRC_SIZE-1] ^ din[i];
        crc_d = {crc_d[CRC_SIZE-2:0], 1'b0};
        if (fb) crc_d = crc_d ^ P;
      end
    end
  end

  always_comb begin
    crc_raw = crc_q;
    if (REF_OUT) begin
      for (int i = 0; i < CRC_SIZE; i++) crc_raw[i] = crc_q[CRC_SIZE-1-i];
    end
    crc_o = crc_raw ^ X;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) crc_q <= I;
    else        crc_q <= crc_d;
  end

endmodule

// File: rtl/crc_frame_appender.sv
// Passes payload through at zero latency, then appends the CRC as NW trailer words; optional frame counter via CRC_FRAME_CNT_EN.
// Backpressure: payload follows m_tready_i combinationally; input is held off (s_tready_o=0) for the trailer and one clear cycle.
module crc_frame_appender
  import crc_frame_pkg::*;
#(
  parameter logic [63:0] POLY          = 64'h1021,
  parameter int          CRC_SIZE      = 16,
  parameter int          DATA_WIDTH    = 8,
  parameter logic [63:0] INIT          = 64'hffff,
  parameter bit          REF_IN        = 1'b1,
  parameter bit          REF_OUT       = 1'b1,
  parameter logic [63:0] XOR_OUT       = 64'h0,
  parameter bit          CRC_LSB_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  input  logic                  m_tready_i,
  output logic [15:0]           frame_cnt_o
);

  localparam int NW = crc_words(CRC_SIZE, DATA_WIDTH);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  if (CRC_SIZE % DATA_WIDTH != 0) begin : g_bad_size
    $error("crc_frame_appender: CRC_SIZE must be a multiple of DATA_WIDTH");
  end

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, sel;
  logic                  en_q;
  logic                  crc_vld, crc_clr;
  logic [CRC_SIZE-1:0]   crc;
  logic [DATA_WIDTH-1:0] crc_word;

  crc_calc #(
    .POLY      (POLY),
    .CRC_SIZE  (CRC_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .INIT      (INIT),
    .REF_IN    (REF_IN),
    .REF_OUT   (REF_OUT),
    .XOR_OUT   (XOR_OUT)
  ) u_crc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .soft_reset_i(crc_clr),
    .valid_i     (crc_vld),
    .data_i      (s_tdata_i),
    .crc_o       (crc)
  );

  always_comb begin
    sel      = CRC_LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    crc_word = crc[sel*DATA_WIDTH +: DATA_WIDTH];
  end

  // en_q keeps both handshakes low during reset and the first cycle after it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s_tready_o = 1'b0;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    m_tdata_o  = s_tdata_i;
    crc_vld    = 1'b0;
    crc_clr    = 1'b0;
    if (en_q) begin
      case (state_q)
        S_DATA: begin
          m_tvalid_o = s_tvalid_i;
          s_tready_o = m_tready_i;
          crc_vld    = s_tvalid_i & m_tready_i;
          if (crc_vld && s_tlast_i) begin
            state_d = S_CRC;
            idx_d   = '0;
          end
        end
        S_CRC: begin
          m_tvalid_o = 1'b1;
          m_tdata_o  = crc_word;
          m_tlast_o  = (idx_q == LAST_IDX);
          if (m_tready_i) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_CLR;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_CLR: begin
          crc_clr = 1'b1;
          state_d = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_DATA;
      idx_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= 1'b1;
    end
  end

`ifdef CRC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (m_tlast_o && m_tready_i) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) frame_cnt_q <= 16'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  assign frame_cnt_o = 16'd0;
`endif

endmodule
